// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage miniRV pipeline.
// Holds the decoded control bundle and operands for the execute stage.
// Detects load-use hazards and raises a one-cycle stall towards PC/IF-ID.
// Squashes the EX slot on a taken branch/jump.
// Counts stall and flush events in saturating counters.
module id_ex_stage #(
  parameter logic [1:0]  WSEL_DRAM = 2'b01,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // decode stage
  input  logic             id_valid_i,
  input  logic [31:0]      id_pc_i,
  input  logic [31:0]      id_rd1_i,
  input  logic [31:0]      id_rd2_i,
  input  logic [31:0]      id_ext_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic             id_rf_we_i,
  input  logic [2:0]       id_br_i,
  input  logic [1:0]       id_rf_wsel_i,
  input  logic             id_ram_we_i,
  input  logic [3:0]       id_alu_op_i,
  input  logic             id_alub_sel_i,
  // execute stage feedback
  input  logic             ex_flush_i,
  // execute stage slot
  output logic             ex_valid_o,
  output logic [31:0]      ex_pc_o,
  output logic [31:0]      ex_rd1_o,
  output logic [31:0]      ex_rd2_o,
  output logic [31:0]      ex_ext_o,
  output logic [4:0]       ex_rd_o,
  output logic             ex_rf_we_o,
  output logic [2:0]       ex_br_o,
  output logic [1:0]       ex_rf_wsel_o,
  output logic             ex_ram_we_o,
  output logic [3:0]       ex_alu_op_o,
  output logic             ex_alub_sel_o,
  // hazard control and statistics
  output logic             stall_o,
  output logic [CNT_W-1:0] cnt_stall_o,
  output logic [CNT_W-1:0] cnt_flush_o
);

  // Contents of the EX slot; an all-zero value is a bubble with no side effect.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic [4:0]  rd;
    logic        rf_we;
    logic [2:0]  br;
    logic [1:0]  rf_wsel;
    logic        ram_we;
    logic [3:0]  alu_op;
    logic        alub_sel;
  } ex_slot_t;

  localparam ex_slot_t BUBBLE = '0;

  ex_slot_t         ex_r;
  ex_slot_t         ex_next_s;
  logic [CNT_W-1:0] cnt_stall_r;
  logic [CNT_W-1:0] cnt_flush_r;
  logic             load_in_ex_s;
  logic             rs1_hit_s;
  logic             rs2_hit_s;
  logic             stall_s;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == {CNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  // Load-use hazard: a load to a nonzero register sits in EX and ID reads it.
  // Only registered EX state and ID inputs feed this, so there is no loop.
  always_comb begin
    load_in_ex_s = ex_r.valid & ex_r.rf_we & (ex_r.rf_wsel == WSEL_DRAM) &
                   (ex_r.rd != 5'd0);
    rs1_hit_s    = id_rs1_used_i & (id_rs1_i == ex_r.rd);
    rs2_hit_s    = id_rs2_used_i & (id_rs2_i == ex_r.rd);
    // A flush means ID holds a wrong-path instruction, so it must not stall.
    stall_s      = load_in_ex_s & id_valid_i & (rs1_hit_s | rs2_hit_s) & ~ex_flush_i;
  end

  // Next EX slot: flush beats stall, stall beats capture; invalid ID is a bubble.
  always_comb begin
    ex_next_s = BUBBLE;
    if (ex_flush_i) begin
      ex_next_s = BUBBLE;
    end else if (stall_s) begin
      ex_next_s = BUBBLE;
    end else if (id_valid_i) begin
      ex_next_s.valid    = 1'b1;
      ex_next_s.pc       = id_pc_i;
      ex_next_s.rd1      = id_rd1_i;
      ex_next_s.rd2      = id_rd2_i;
      ex_next_s.ext      = id_ext_i;
      ex_next_s.rd       = id_rd_i;
      ex_next_s.rf_we    = id_rf_we_i;
      ex_next_s.br       = id_br_i;
      ex_next_s.rf_wsel  = id_rf_wsel_i;
      ex_next_s.ram_we   = id_ram_we_i;
      ex_next_s.alu_op   = id_alu_op_i;
      ex_next_s.alub_sel = id_alub_sel_i;
    end else begin
      ex_next_s = BUBBLE;
    end
  end

  // EX slot register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_r <= BUBBLE;
    end else begin
      ex_r <= ex_next_s;
    end
  end

  // Saturating event counters for stalls and flushes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_stall_r <= {CNT_W{1'b0}};
      cnt_flush_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s) begin
        cnt_stall_r <= sat_inc(cnt_stall_r);
      end else begin
        cnt_stall_r <= cnt_stall_r;
      end
      if (ex_flush_i) begin
        cnt_flush_r <= sat_inc(cnt_flush_r);
      end else begin
        cnt_flush_r <= cnt_flush_r;
      end
    end
  end

  assign ex_valid_o    = ex_r.valid;
  assign ex_pc_o       = ex_r.pc;
  assign ex_rd1_o      = ex_r.rd1;
  assign ex_rd2_o      = ex_r.rd2;
  assign ex_ext_o      = ex_r.ext;
  assign ex_rd_o       = ex_r.rd;
  assign ex_rf_we_o    = ex_r.rf_we;
  assign ex_br_o       = ex_r.br;
  assign ex_rf_wsel_o  = ex_r.rf_wsel;
  assign ex_ram_we_o   = ex_r.ram_we;
  assign ex_alu_op_o   = ex_r.alu_op;
  assign ex_alub_sel_o = ex_r.alub_sel;
  assign stall_o       = stall_s;
  assign cnt_stall_o   = cnt_stall_r;
  assign cnt_flush_o   = cnt_flush_r;

endmodule
